// File: rtl/pkt_burst_writer.sv
// Packet-to-memory Avalon-MM burst writer fed from a show-ahead FIFO.
// Optional BURST_4K_SPLIT_EN: bursts never cross a 4 KiB boundary.
module pkt_burst_writer #(
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 16,
   parameter int USEDW_W   = 9
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [31:0]                 cfg_addr,
   input  logic [LEN_W-1:0]            cfg_len,
   output logic                        busy,
   output logic                        done,
   input  logic [DATA_W-1:0]           fifo_rdata,
   input  logic                        fifo_empty,
   input  logic [USEDW_W-1:0]          fifo_usedw,
   output logic                        fifo_rd,
   output logic [31:0]                 avm_address,
   output logic [DATA_W-1:0]           avm_writedata,
   output logic [DATA_W/8-1:0]         avm_byteenable,
   output logic                        avm_write,
   output logic [$clog2(MAX_BURST):0]  avm_burstcount,
   input  logic                        avm_waitrequest
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFS_W = $clog2(BYTES);
   localparam int BC_W  = $clog2(MAX_BURST) + 1;
   localparam int CW    = USEDW_W + BC_W;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      BURST,
      DONE
   } state_t;

   state_t            state;
   logic [31:0]       cur_addr;
   logic [LEN_W-1:0]  word_rem;
   logic [OFS_W-1:0]  tail;
   logic [BC_W-1:0]   beat_cnt;
   logic [BC_W-1:0]   blen_c;
   logic [LEN_W:0]    words_c;
   logic [LEN_W-1:0]  rem_next;
   logic [BYTES-1:0]  last_be;
   logic              fill_ok;
   logic              unused_ok;

   assign words_c  = ({1'b0, cfg_len} + (LEN_W+1)'(BYTES - 1)) >> OFS_W;
   assign rem_next = word_rem - LEN_W'(avm_burstcount);
   assign fill_ok  = CW'(fifo_usedw) >= CW'(blen_c);

   assign fifo_rd       = avm_write & ~avm_waitrequest;
   assign avm_writedata = fifo_rdata;

   // fifo_empty is not acted on: FILL already guarantees a full burst of data.
   assign unused_ok = &{1'b0, fifo_empty, cfg_addr[OFS_W-1:0], words_c[LEN_W]};

`ifdef BURST_4K_SPLIT_EN
   logic [12:0] to4k;
   assign to4k = (13'h1000 - {1'b0, cur_addr[11:0]}) >> OFS_W;
`endif

   always_comb begin
      blen_c = BC_W'(MAX_BURST);
      if (word_rem < LEN_W'(MAX_BURST))
         blen_c = BC_W'(word_rem);
`ifdef BURST_4K_SPLIT_EN
      if (to4k < 13'(blen_c))
         blen_c = BC_W'(to4k);
`endif
   end

   always_comb begin
      last_be = '0;
      for (int i = 0; i < BYTES; i++)
         last_be[i] = (tail == '0) || (OFS_W'(i) < tail);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_burstcount <= '0;
         avm_byteenable <= '1;
         cur_addr       <= '0;
         word_rem       <= '0;
         tail           <= '0;
         beat_cnt       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  cur_addr <= {cfg_addr[31:OFS_W], OFS_W'(0)};
                  word_rem <= words_c[LEN_W-1:0];
                  tail     <= cfg_len[OFS_W-1:0];
                  state    <= (cfg_len == '0) ? DONE : FILL;
               end
            end
            FILL: begin
               if (fill_ok) begin
                  avm_address    <= cur_addr;
                  avm_burstcount <= blen_c;
                  beat_cnt       <= blen_c;
                  avm_write      <= 1'b1;
                  avm_byteenable <= (word_rem == LEN_W'(1)) ? last_be : '1;
                  state          <= BURST;
               end
            end
            BURST: begin
               if (!avm_waitrequest) begin
                  beat_cnt <= beat_cnt - BC_W'(1);
                  if (beat_cnt == BC_W'(1)) begin
                     avm_write      <= 1'b0;
                     avm_byteenable <= '1;
                     cur_addr       <= cur_addr + (32'(avm_burstcount) << OFS_W);
                     word_rem       <= rem_next;
                     state          <= (rem_next == '0) ? DONE : FILL;
                  end else begin
                     // next beat is the packet's final one: apply the tail mask
                     avm_byteenable <= (beat_cnt == BC_W'(2) && rem_next == '0)
                                       ? last_be : '1;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
